// File: rtl/cu_seq.sv
// Microcode sequencer: fetches an instruction byte over SPI, then walks its micro-steps.
// Optional interrupt entry at ADVANCE is built when CU_SEQ_IRQ_EN is defined.
// dbg_state encoding: 0 FETCH_SPI, 1 LOAD_IR, 2 STEP, 3 STEP_SPI, 4 STEP_EVENTS, 5 ADVANCE.
module cu_seq #(
   parameter int                PC_W        = 16,
   parameter int                STEP_W      = 2,
   parameter logic [8:0]        FETCH_UWORD = 9'h050,
   parameter logic [3:0]        SPI_IN_CODE = 4'd2,
   parameter logic [2:0]        SPI_OUT_A   = 3'd5,
   parameter logic [2:0]        SPI_OUT_B   = 3'd6,
   parameter logic [PC_W-1:0]   IRQ_VECTOR  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 halt,
   input  logic                 spi_done,
   output logic                 spi_executing,
   input  logic [7:0]           irin,
   output logic [8+STEP_W-1:0]  uaddr,
   input  logic [8:0]           uword,
   input  logic                 pcinflag,
   input  logic [PC_W-1:0]      pcin,
   output logic [PC_W-1:0]      pc,
   output logic                 input_we,
   output logic                 highbits_we,
   output logic [3:0]           inflags,
   output logic [2:0]           outflags,
   output logic [7:0]           cuout,
   output logic [STEP_W-1:0]    step,
`ifdef CU_SEQ_IRQ_EN
   input  logic                 irq,
   output logic                 irq_ack,
   output logic [PC_W-1:0]      epc,
`endif
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      FETCH_SPI   = 3'd0,
      LOAD_IR     = 3'd1,
      STEP        = 3'd2,
      STEP_SPI    = 3'd3,
      STEP_EVENTS = 3'd4,
      ADVANCE     = 3'd5
   } state_t;

   localparam logic [STEP_W-1:0] STEP_LAST = '1;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [7:0]          ir_q, ir_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                spi_exec_q, spi_exec_d;
`ifdef CU_SEQ_IRQ_EN
   logic [PC_W-1:0]     epc_q, epc_d;
`endif

   logic [8:0]          mw;
   logic                u_last, u_pcc, spi_need;

   // During fetch the memory is not yet addressed by a real opcode, so a fixed word drives the flags.
   assign mw       = (state_q == FETCH_SPI || state_q == LOAD_IR) ? FETCH_UWORD : uword;
   assign u_last   = mw[8];
   assign u_pcc    = mw[7];
   assign spi_need = u_pcc || (mw[3:0] == SPI_IN_CODE) ||
                     (mw[6:4] == SPI_OUT_A) || (mw[6:4] == SPI_OUT_B);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      step_d     = step_q;
      spi_exec_d = spi_exec_q;
`ifdef CU_SEQ_IRQ_EN
      epc_d      = epc_q;
      irq_ack    = 1'b0;
`endif
      if (!halt) begin
         case (state_q)
            FETCH_SPI: begin
               if (spi_done) begin
                  spi_exec_d = 1'b0;
                  state_d    = LOAD_IR;
               end else begin
                  spi_exec_d = 1'b1;
               end
            end
            LOAD_IR: begin
               ir_d    = irin;
               step_d  = '0;
               state_d = STEP;
            end
            STEP: begin
               if (u_pcc) pc_d = pc_q + PC_W'(1);
               if (spi_need) begin
                  spi_exec_d = 1'b1;
                  state_d    = STEP_SPI;
               end else begin
                  state_d = STEP_EVENTS;
               end
            end
            STEP_SPI: begin
               if (spi_done) begin
                  spi_exec_d = 1'b0;
                  state_d    = STEP_EVENTS;
               end
            end
            STEP_EVENTS: begin
               if (u_last || step_q == STEP_LAST) begin
                  state_d = ADVANCE;
               end else begin
                  step_d  = step_q + STEP_W'(1);
                  state_d = STEP;
               end
            end
            ADVANCE: begin
               step_d  = '0;
               state_d = FETCH_SPI;
               // A taken jump wins over a pending interrupt; the interrupt is taken next time.
               if (pcinflag) pc_d = pcin;
`ifdef CU_SEQ_IRQ_EN
               else if (irq) begin
                  epc_d   = pc_q + PC_W'(1);
                  pc_d    = IRQ_VECTOR;
                  irq_ack = 1'b1;
               end
`endif
               else pc_d = pc_q + PC_W'(1);
            end
            default: state_d = FETCH_SPI;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH_SPI;
         pc_q       <= '0;
         ir_q       <= '0;
         step_q     <= '0;
         spi_exec_q <= 1'b0;
`ifdef CU_SEQ_IRQ_EN
         epc_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         step_q     <= step_d;
         spi_exec_q <= spi_exec_d;
`ifdef CU_SEQ_IRQ_EN
         epc_q      <= epc_d;
`endif
      end
   end

   assign input_we      = (state_q == LOAD_IR) || (state_q == STEP_EVENTS) || (state_q == ADVANCE);
   assign highbits_we   = (state_q == STEP_EVENTS) && (step_q == '0);
   assign spi_executing = spi_exec_q;
   assign uaddr         = {ir_q, step_q};
   assign inflags       = mw[3:0];
   assign outflags      = mw[6:4];
   assign pc            = pc_q;
   assign cuout         = ir_q;
   assign step          = step_q;
   assign dbg_state     = state_q;
`ifdef CU_SEQ_IRQ_EN
   assign epc           = epc_q;
`endif

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq: microcode ROM model on uaddr/uword, hand-computed expectations.
// The interrupt scenario is included when CU_SEQ_IRQ_EN is defined.
module tb_cu_seq;

   localparam int PC_W   = 16;
   localparam int STEP_W = 2;

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_STEP    = 3'd2;
   localparam logic [2:0] S_SPI     = 3'd3;
   localparam logic [2:0] S_EVENTS  = 3'd4;
   localparam logic [2:0] S_ADVANCE = 3'd5;

   logic                 clk, rst, halt, spi_done, spi_executing;
   logic [7:0]           irin, cuout;
   logic [8+STEP_W-1:0]  uaddr;
   logic [8:0]           uword;
   logic                 pcinflag, input_we, highbits_we;
   logic [PC_W-1:0]      pcin, pc;
   logic [3:0]           inflags;
   logic [2:0]           outflags, dbg_state;
   logic [STEP_W-1:0]    step;
`ifdef CU_SEQ_IRQ_EN
   logic                 irq, irq_ack;
   logic [PC_W-1:0]      epc;
`endif

   logic [8:0] ucode [0:1023];

   int n_tests = 0;
   int n_fail  = 0;

   cu_seq #(.PC_W(PC_W), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .halt(halt), .spi_done(spi_done),
      .spi_executing(spi_executing), .irin(irin), .uaddr(uaddr), .uword(uword),
      .pcinflag(pcinflag), .pcin(pcin), .pc(pc), .input_we(input_we),
      .highbits_we(highbits_we), .inflags(inflags), .outflags(outflags),
      .cuout(cuout), .step(step),
`ifdef CU_SEQ_IRQ_EN
      .irq(irq), .irq_ack(irq_ack), .epc(epc),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign uword = ucode[uaddr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      halt     = 1'b0;
      spi_done = 1'b0;
      pcinflag = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // From FETCH_SPI with the request low: raise request, answer it, load the opcode; ends in STEP.
   task automatic fetch(input logic [7:0] op);
      irin = op;
      tick();
      check_eq("fetch_req", spi_executing, 1'b1);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      check_eq("load_state", dbg_state, S_LOAD);
      tick();
      check_eq("ir_loaded", cuout, op);
      check_eq("step_state", dbg_state, S_STEP);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_ev;
      bit  seen;

      for (int i = 0; i < 1024; i++) ucode[i] = 9'h100;
      ucode[{8'h34, 2'd0}] = 9'h080;
      ucode[{8'h34, 2'd1}] = 9'h100;
      for (int s = 0; s < 4; s++) ucode[{8'h56, s[1:0]}] = 9'h000;
      ucode[{8'hBC, 2'd0}] = 9'h160;
      ucode[{8'h9A, 2'd0}] = 9'h182;
      irin = 8'h00;
      pcin = '0;
`ifdef CU_SEQ_IRQ_EN
      irq = 1'b0;
`endif
      rst = 1'b1; halt = 1'b0; spi_done = 1'b0; pcinflag = 1'b0;
      tick();
      tick();
      check_eq("rst_pc", pc, 16'h0000);
      check_eq("rst_ir", cuout, 8'h00);
      check_eq("rst_step", step, 2'd0);
      check_eq("rst_spi", spi_executing, 1'b0);
      check_eq("rst_state", dbg_state, S_FETCH);
      check_eq("fetch_outflags", outflags, 3'd5);
      rst = 1'b0;

      // single LAST step, no SPI in the step
      fetch(8'h12);
      check_eq("t1_uaddr", uaddr, 10'h048);
      check_eq("t1_spi_idle", spi_executing, 1'b0);
      tick();
      check_eq("t1_events", dbg_state, S_EVENTS);
      check_eq("t1_highbits", highbits_we, 1'b1);
      check_eq("t1_input_we", input_we, 1'b1);
      tick();
      check_eq("t1_advance", dbg_state, S_ADVANCE);
      check_eq("t1_highbits_adv", highbits_we, 1'b0);
      tick();
      check_eq("t1_pc", pc, 16'h0001);
      check_eq("t1_back_fetch", dbg_state, S_FETCH);

      // PCC step then LAST step
      do_reset();
      fetch(8'h34);
      tick();
      check_eq("t2_pcc_pc", pc, 16'h0001);
      check_eq("t2_spi_req", spi_executing, 1'b1);
      check_eq("t2_step_spi", dbg_state, S_SPI);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      check_eq("t2_spi_drop", spi_executing, 1'b0);
      check_eq("t2_events0", dbg_state, S_EVENTS);
      tick();
      check_eq("t2_step1", step, 2'd1);
      check_eq("t2_uaddr1", uaddr, 10'h0D1);
      tick();
      check_eq("t2_highbits1", highbits_we, 1'b0);
      tick();
      tick();
      check_eq("t2_pc_final", pc, 16'h0002);

      // no LAST bit: all four steps run
      do_reset();
      fetch(8'h56);
      n_ev = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (dbg_state == S_EVENTS) n_ev++;
         if (dbg_state == S_ADVANCE) seen = 1'b1;
         else tick();
      end
      check_eq("t3_adv_reached", seen, 1'b1);
      check_eq("t3_step_count", n_ev, 4);
      check_eq("t3_last_step", step, 2'd3);
      tick();
      check_eq("t3_pc", pc, 16'h0001);
      check_eq("t3_step_clr", step, 2'd0);

      // jump to top of range, then wrap; stray spi_done outside SPI states
      do_reset();
      pcinflag = 1'b1;
      pcin     = 16'hFFFF;
      fetch(8'h78);
      tick();
      tick();
      tick();
      check_eq("t4_jump", pc, 16'hFFFF);
      pcinflag = 1'b0;
      fetch(8'h78);
      spi_done = 1'b1;
      tick();
      check_eq("t4_stray_state", dbg_state, S_EVENTS);
      check_eq("t4_stray_spi", spi_executing, 1'b0);
      tick();
      check_eq("t4_stray_adv", dbg_state, S_ADVANCE);
      spi_done = 1'b0;
      tick();
      check_eq("t4_wrap", pc, 16'h0000);

      // outflags SPI_OUT_B forces step SPI
      fetch(8'hBC);
      check_eq("t5_outflags", outflags, 3'd6);
      tick();
      check_eq("t5_step_spi", dbg_state, S_SPI);
      check_eq("t5_spi_req", spi_executing, 1'b1);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      tick();
      check_eq("t5_pc", pc, 16'h0001);

      // inflags SPI_IN_CODE with PCC; halt then async reset in STEP_SPI
      fetch(8'h9A);
      check_eq("t6_inflags", inflags, 4'd2);
      tick();
      check_eq("t6_step_spi", dbg_state, S_SPI);
      check_eq("t6_pc", pc, 16'h0002);
      halt     = 1'b1;
      spi_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("t6_halt_state", dbg_state, S_SPI);
         check_eq("t6_halt_spi", spi_executing, 1'b1);
         check_eq("t6_halt_pc", pc, 16'h0002);
      end
      halt     = 1'b0;
      spi_done = 1'b0;
      tick();
      check_eq("t6_wait_spi", dbg_state, S_SPI);
      rst = 1'b1;
      #2;
      check_eq("t6_async_spi", spi_executing, 1'b0);
      check_eq("t6_async_pc", pc, 16'h0000);
      check_eq("t6_async_state", dbg_state, S_FETCH);
      check_eq("t6_async_ir", cuout, 8'h00);
      tick();
      rst = 1'b0;

`ifdef CU_SEQ_IRQ_EN
      pcinflag = 1'b1;
      pcin     = 16'h0040;
      fetch(8'h78);
      tick();
      tick();
      tick();
      check_eq("irq_pre_pc", pc, 16'h0040);
      pcinflag = 1'b0;
      irq      = 1'b1;
      fetch(8'h78);
      tick();
      tick();
      check_eq("irq_ack_hi", irq_ack, 1'b1);
      tick();
      irq = 1'b0;
      check_eq("irq_ack_lo", irq_ack, 1'b0);
      check_eq("irq_pc", pc, 16'h0000);
      check_eq("irq_epc", epc, 16'h0041);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cu_seq.md
CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 SHALL provide parameter PC_W, default 16, program counter width.
REQ-002 SHALL provide parameter STEP_W, default 2, step index width; STEPS = 2**STEP_W micro-steps per instruction maximum.
REQ-003 SHALL provide parameter FETCH_UWORD, default 9'h050, microword driven during fetch.
REQ-004 SHALL provide parameter SPI_IN_CODE, default 2, inflags value requiring SPI.
REQ-005 SHALL provide parameters SPI_OUT_A, default 5, and SPI_OUT_B, default 6, outflags values requiring SPI.
REQ-006 SHALL provide parameter IRQ_VECTOR, default 0, interrupt target PC (PC_W bits).
REQ-007 clk  input  1  clock, rising edge active.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 halt  input  1  freezes all state while high.
REQ-010 spi_done  input  1  SPI transfer complete strobe.
REQ-011 spi_executing  output  1  SPI transfer request, held until spi_done.
REQ-012 irin  input  8  instruction byte from memory.
REQ-013 uaddr  output  8+STEP_W  microcode address {ir, step}.
REQ-014 uword  input  9  microword for uaddr, same cycle: [8] LAST, [7] PCC, [6:4] outflags, [3:0] inflags.
REQ-015 pcinflag  input  1  jump taken; pcin  input  PC_W  jump target.
REQ-016 pc  output  PC_W; input_we  output  1; highbits_we  output  1; inflags  output  4; outflags  output  3; cuout  output  8 (ir register); step  output  STEP_W.

Function
REQ-017 States SHALL be FETCH_SPI, LOAD_IR, STEP, STEP_SPI, STEP_EVENTS, ADVANCE.
REQ-018 FETCH_SPI: spi_executing=1; on spi_done -> spi_executing=0, LOAD_IR.
REQ-019 LOAD_IR: ir<=irin, step<=0, -> STEP.
REQ-020 STEP: if PCC or inflags==SPI_IN_CODE or outflags in {SPI_OUT_A,SPI_OUT_B} -> spi_executing=1, STEP_SPI; else STEP_EVENTS; PCC SHALL increment pc by 1 (mod 2**PC_W) in this cycle.
REQ-021 STEP_SPI: wait for spi_done, then spi_executing=0, -> STEP_EVENTS.
REQ-022 STEP_EVENTS: if LAST=1 or step==STEPS-1 -> ADVANCE; else step<=step+1, -> STEP.
REQ-023 ADVANCE: pc<=pcin if pcinflag, else pc+1 (wraps); step<=0; -> FETCH_SPI.
REQ-024 Microword in effect SHALL be FETCH_UWORD in FETCH_SPI/LOAD_IR, else uword; inflags/outflags decode from it.
REQ-025 input_we SHALL be 1 in LOAD_IR, STEP_EVENTS, ADVANCE.
REQ-026 highbits_we SHALL be 1 only in STEP_EVENTS with step==0.
REQ-027 halt high SHALL hold state, pc, ir, step, spi_executing unchanged; spi_done ignored while halted.
REQ-028 spi_done outside FETCH_SPI/STEP_SPI SHALL be ignored.

Reset
REQ-029 rst SHALL set state=FETCH_SPI, pc=0, ir=0, step=0, spi_executing=0 immediately, including mid-transfer; outputs SHALL take reset values without clock.

Configuration
REQ-030 With CU_SEQ_IRQ_EN defined: ports irq (input 1), irq_ack (output 1), epc (output PC_W) SHALL exist; in ADVANCE with irq=1 and pcinflag=0, epc<=pc+1, pc<=IRQ_VECTOR, irq_ack=1 for that cycle; pcinflag has priority (irq deferred). epc resets to 0.
REQ-031 Without CU_SEQ_IRQ_EN: ports absent, ADVANCE behaves per REQ-023 only.

Verification
REQ-032 Reset, spi_done pulse, irin=8'h12, uword step0=9'h100 -> ir=8'h12, pc=1 after ADVANCE, one step executed.
REQ-033 uword=9'h080 step0, 9'h100 step1 -> pc increments in STEP (to 1), spi_executing re-raised, final pc=2.
REQ-034 STEP_W=2, uword LAST never set -> exactly 4 steps, then ADVANCE.
REQ-035 pcinflag=1, pcin=16'hFFFF then next instruction no jump -> pc=16'hFFFF, then wraps to 0.
REQ-036 rst asserted in STEP_SPI -> spi_executing=0, pc=0 asynchronously; halt held 5 cycles in STEP_SPI with spi_done -> no state change.
REQ-037 CU_SEQ_IRQ_EN, irq=1 at ADVANCE, pc=16'h0040 -> pc=IRQ_VECTOR, epc=16'h0041, irq_ack one cycle.
